// File: rtl/banco_registradores_param_if.sv
`default_nettype none
// ============================================================================
// Module   : banco_registradores_param_if
// Purpose  : Read/write/issue/clear bus of the parametrised register bank.
// Revision : 1.0  initial release
// ============================================================================
interface banco_registradores_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_pend1;
  logic              rd_pend2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              clear_req;
  logic              busy;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, issue_en, issue_addr, clear_req,
    input  rd_data1, rd_data2, rd_pend1, rd_pend2, busy
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, issue_en, issue_addr, clear_req,
    output rd_data1, rd_data2, rd_pend1, rd_pend2, busy
  );
endinterface
`default_nettype wire

// File: rtl/banco_registradores_param.sv
`default_nettype none
// ============================================================================
// Module   : banco_registradores_param
// Purpose  : 2R/1W register bank (reg 0 = 0) with pending scoreboard,
//            optional write-to-read bypass and a sequential clear sweep.
// Revision : 1.0  initial release
// ============================================================================
module banco_registradores_param #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BYPASS = 1
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  banco_registradores_param_if.slave bus_io
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] regs_q [1:DEPTH-1];
  logic [DATA_W-1:0] regs_d [1:DEPTH-1];
  logic [DATA_W-1:0] w_mem  [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              w_busy;
  logic              w_wr_fire;
  logic              w_iss_fire;
  logic [DATA_W-1:0] w_raw_d1, w_raw_d2;
  logic              w_raw_p1, w_raw_p2;

  assign w_busy     = (state_q == S_SWEEP);
  assign w_wr_fire  = bus_io.wr_en    && !w_busy && (bus_io.wr_addr    != '0);
  assign w_iss_fire = bus_io.issue_en && !w_busy && (bus_io.issue_addr != '0);
  assign bus_io.busy = w_busy;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (bus_io.clear_req) begin
          state_d = S_SWEEP;
          ptr_d   = ADDR_W'(1);
        end
      end
      S_SWEEP: begin
        ptr_d = ptr_q + ADDR_W'(1);
        // Leave before the pointer can wrap back onto reg 0.
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = S_IDLE;
          ptr_d   = ADDR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = ADDR_W'(1);
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      ptr_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    for (int i = 1; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (w_busy) begin
        if (ptr_q == ADDR_W'(i)) regs_d[i] = '0;
      end else if (w_wr_fire && (bus_io.wr_addr == ADDR_W'(i))) begin
        regs_d[i] = bus_io.wr_data;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 1; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Issue is applied after the write so a same-address pair leaves pend set.
  always_comb begin
    pend_d = pend_q;
    if (w_busy) begin
      pend_d[ptr_q] = 1'b0;
    end else begin
      if (w_wr_fire)  pend_d[bus_io.wr_addr]    = 1'b0;
      if (w_iss_fire) pend_d[bus_io.issue_addr] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  always_comb begin
    w_mem[0] = '0;
    for (int i = 1; i < DEPTH; i++) w_mem[i] = regs_q[i];
  end

  assign w_raw_d1 = w_mem[bus_io.rd_addr1];
  assign w_raw_d2 = w_mem[bus_io.rd_addr2];
  assign w_raw_p1 = pend_q[bus_io.rd_addr1];
  assign w_raw_p2 = pend_q[bus_io.rd_addr2];

  generate
    if (BYPASS != 0) begin : g_bypass
      logic w_hit1, w_hit2, w_iss_hit1, w_iss_hit2;
      assign w_hit1     = w_wr_fire  && (bus_io.wr_addr    == bus_io.rd_addr1);
      assign w_hit2     = w_wr_fire  && (bus_io.wr_addr    == bus_io.rd_addr2);
      assign w_iss_hit1 = w_iss_fire && (bus_io.issue_addr == bus_io.rd_addr1);
      assign w_iss_hit2 = w_iss_fire && (bus_io.issue_addr == bus_io.rd_addr2);
      assign bus_io.rd_data1 = w_hit1 ? bus_io.wr_data : w_raw_d1;
      assign bus_io.rd_data2 = w_hit2 ? bus_io.wr_data : w_raw_d2;
      assign bus_io.rd_pend1 = w_hit1 ? w_iss_hit1 : w_raw_p1;
      assign bus_io.rd_pend2 = w_hit2 ? w_iss_hit2 : w_raw_p2;
    end else begin : g_no_bypass
      assign bus_io.rd_data1 = w_raw_d1;
      assign bus_io.rd_data2 = w_raw_d2;
      assign bus_io.rd_pend1 = w_raw_p1;
      assign bus_io.rd_pend2 = w_raw_p2;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_banco_registradores_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_banco_registradores_param
// Purpose  : Directed scoreboard bench for banco_registradores_param (BYPASS=1
//            instance fully checked, BYPASS=0 twin checked on read port 1 data).
// Revision : 1.0  initial release
// ============================================================================
module tb_banco_registradores_param;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam logic [31:0] Z = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  banco_registradores_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  banco_registradores_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_nb ();

  assign bus_nb.rd_addr1   = bus.rd_addr1;
  assign bus_nb.rd_addr2   = bus.rd_addr2;
  assign bus_nb.wr_en      = bus.wr_en;
  assign bus_nb.wr_addr    = bus.wr_addr;
  assign bus_nb.wr_data    = bus.wr_data;
  assign bus_nb.issue_en   = bus.issue_en;
  assign bus_nb.issue_addr = bus.issue_addr;
  assign bus_nb.clear_req  = bus.clear_req;

  banco_registradores_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BYPASS(1)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus_io  (bus)
  );

  banco_registradores_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BYPASS(0)) dut_nb (
    .clock_i (clk),
    .reset_i (rst),
    .bus_io  (bus_nb)
  );

  typedef struct {
    string       tag;
    logic [31:0] d1;
    logic        p1;
    logic [31:0] d2;
    logic        p2;
    logic        bsy;
    logic [31:0] nbd1;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] fillv(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0111;
  endfunction

  task automatic push(input string tag, input logic [31:0] d1, input logic p1,
                      input logic [31:0] d2, input logic p2, input logic bsy,
                      input logic [31:0] nbd1);
    exp_t e;
    e.tag = tag; e.d1 = d1; e.p1 = p1; e.d2 = d2; e.p2 = p2; e.bsy = bsy; e.nbd1 = nbd1;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en     = 1'b0;
    bus.issue_en  = 1'b0;
    bus.clear_req = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(a);
    bus.wr_data = d;
  endtask

  task automatic iss(input int a);
    bus.issue_en   = 1'b1;
    bus.issue_addr = ADDR_W'(a);
  endtask

  task automatic rd(input int a1, input int a2);
    bus.rd_addr1 = ADDR_W'(a1);
    bus.rd_addr2 = ADDR_W'(a2);
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      m_e = sb_q.pop_front();
      checks++;
      if (bus.rd_data1 !== m_e.d1 || bus.rd_pend1 !== m_e.p1 ||
          bus.rd_data2 !== m_e.d2 || bus.rd_pend2 !== m_e.p2 ||
          bus.busy !== m_e.bsy || bus_nb.rd_data1 !== m_e.nbd1) begin
        errors++;
        $display("FAIL %s: got d1=%h p1=%b d2=%h p2=%b busy=%b nb_d1=%h, want d1=%h p1=%b d2=%h p2=%b busy=%b nb_d1=%h",
                 m_e.tag, bus.rd_data1, bus.rd_pend1, bus.rd_data2, bus.rd_pend2, bus.busy,
                 bus_nb.rd_data1, m_e.d1, m_e.p1, m_e.d2, m_e.p2, m_e.bsy, m_e.nbd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] e1, e2;
    idle();
    rd(0, 0);
    bus.wr_addr = '0; bus.wr_data = '0; bus.issue_addr = '0;

    cyc(); push("reset_hold", Z, 1'b0, Z, 1'b0, 1'b0, Z);
    cyc(); rst = 1'b0;

    for (int a = 0; a < 16; a++) begin
      cyc(); rd(a, 15 - a);
      push("t1_zero", Z, 1'b0, Z, 1'b0, 1'b0, Z);
    end

    cyc(); wr(5, 32'hDEADBEEF); rd(5, 0);
    push("t2_wr_byp", 32'hDEADBEEF, 1'b0, Z, 1'b0, 1'b0, Z);
    cyc(); idle();
    push("t2_read", 32'hDEADBEEF, 1'b0, Z, 1'b0, 1'b0, 32'hDEADBEEF);
    cyc(); wr(0, 32'h0000_1234); rd(0, 5);
    push("t2_r0_wr", Z, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, Z);
    cyc(); idle();
    push("t2_r0_read", Z, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, Z);

    cyc(); wr(3, 32'hA5A5A5A5); rd(3, 3);
    push("t3_byp", 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, Z);
    cyc(); idle();
    push("t3_after", 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 32'hA5A5A5A5);

    cyc(); iss(7); rd(7, 0);
    push("t4_issue", Z, 1'b0, Z, 1'b0, 1'b0, Z);
    cyc(); idle();
    push("t4_pend", Z, 1'b1, Z, 1'b0, 1'b0, Z);
    cyc(); wr(7, 32'h0000_0077);
    push("t4_wr_byp", 32'h77, 1'b0, Z, 1'b0, 1'b0, Z);
    cyc(); idle();
    push("t4_pend_clr", 32'h77, 1'b0, Z, 1'b0, 1'b0, 32'h77);
    cyc(); wr(7, 32'h0000_0088); iss(7);
    push("t4_both_byp", 32'h88, 1'b1, Z, 1'b0, 1'b0, 32'h77);
    cyc(); idle();
    push("t4_both", 32'h88, 1'b1, Z, 1'b0, 1'b0, 32'h88);
    cyc(); iss(0);
    push("t4_r0_issue", 32'h88, 1'b1, Z, 1'b0, 1'b0, 32'h88);
    cyc(); idle();
    push("t4_r0_pend", 32'h88, 1'b1, Z, 1'b0, 1'b0, 32'h88);

    for (int i = 1; i < 16; i++) begin
      cyc(); idle(); wr(i, fillv(i));
    end
    cyc(); idle(); wr(15, 32'h0000_F00D); bus.clear_req = 1'b1; rd(1, 2);
    push("t5_start", fillv(1), 1'b0, fillv(2), 1'b0, 1'b0, fillv(1));
    for (int k = 1; k <= 15; k++) begin
      cyc(); idle(); rd(k, k - 1);
      e2 = Z;
      if (k == 3) begin
        wr(14, 32'h0000_0BAD); rd(3, 14); e2 = fillv(14);
      end
      if (k == 8)  bus.clear_req = 1'b1;
      if (k == 14) iss(13);
      e1 = (k == 15) ? 32'h0000_F00D : fillv(k);
      push("t5_sweep", e1, 1'b0, e2, 1'b0, 1'b1, e1);
    end
    for (int a = 0; a < 16; a++) begin
      cyc(); idle(); rd(a, 15 - a);
      push("t5_cleared", Z, 1'b0, Z, 1'b0, 1'b0, Z);
    end

    for (int i = 1; i < 16; i++) begin
      cyc(); idle(); wr(i, fillv(i));
    end
    cyc(); idle(); iss(9);
    cyc(); idle(); bus.clear_req = 1'b1; rd(1, 9);
    push("t6_start", fillv(1), 1'b0, fillv(9), 1'b1, 1'b0, fillv(1));
    for (int k = 1; k <= 3; k++) begin
      cyc(); idle(); rd(k, 9);
      push("t6_sweep", fillv(k), 1'b0, fillv(9), 1'b1, 1'b1, fillv(k));
    end
    cyc(); idle(); rd(10, 9);
    push("t6_mid_reset", Z, 1'b0, Z, 1'b0, 1'b0, Z);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    cyc(); wr(6, 32'h0000_600D); rd(6, 9);
    push("t6_first_wr", 32'h600D, 1'b0, Z, 1'b0, 1'b0, Z);
    cyc(); idle();
    push("t6_read", 32'h600D, 1'b0, Z, 1'b0, 1'b0, 32'h600D);

    cyc(); cyc();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
